apb_slave_mem: RTL and testbench

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 126 ++++++++++++
 tb/tb_apb_slave_mem.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 slave backed by a 2^AWIDTH x 32 word memory.
// Programmable wait states, address error response, protocol-abort handling.
module apb_slave_mem #(
    parameter int AWIDTH      = 8,
    parameter int WAIT_STATES = 0,
    parameter int TPD         = 1
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    // TPD is carried for back-annotated simulation flows; the RTL is zero-delay.
    if (WAIT_STATES < 0 || WAIT_STATES > 15 || TPD < 0 ||
        AWIDTH < 1 || AWIDTH > 30) begin : g_bad_param
        $error("apb_slave_mem: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [AWIDTH-1:0] addr_q;
    logic              write_q;
    logic              err_q;

    logic [31:0]       mem [2**AWIDTH];

    logic [AWIDTH-1:0] idx;
    logic              addr_err;
    logic              setup;
    logic              done;

    // Word index and error decode of the address presented on the bus
    assign idx      = PADDR[AWIDTH+1:2];
    assign addr_err = (PADDR[1:0] != 2'b00) ||
                      ((PADDR >> (AWIDTH + 2)) != 32'd0);
    assign setup    = (state == IDLE) && PSEL && !PENABLE;
    assign done     = (state == READY) && PSEL && PENABLE;

    // Transfer FSM with registered PREADY/PSLVERR/PRDATA
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            PRDATA  <= 32'd0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        addr_q  <= idx;
                        write_q <= PWRITE;
                        err_q   <= addr_err;
                        cnt     <= 4'(WAIT_STATES);
                        PRDATA  <= (!PWRITE && !addr_err) ? mem[idx] : 32'd0;
                        if (WAIT_STATES == 0) begin
                            state   <= READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= addr_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!PSEL) begin
                        // master dropped the transfer: abort quietly
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        PRDATA  <= 32'd0;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end else if (PENABLE) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_q;
                        end
                    end
                end
                READY: begin
                    if (!PSEL || PENABLE) begin
                        // completion or abort both end in a quiet IDLE
                        state   <= IDLE;
                        cnt     <= 4'd0;
                        PRDATA  <= 32'd0;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= 4'd0;
                    PRDATA  <= 32'd0;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
            endcase
        end
    end

    // Commit PWDATA on the completion edge of an error-free write
    always_ff @(posedge PCLK) begin
        if (done && write_q && !err_q) begin
            mem[addr_q] <= PWDATA;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed checks of apb_slave_mem with 0, 2 and 3
// wait states sharing one APB bus, one PSEL bit per instance.
module tb_apb_slave_mem;

    localparam int D0 = 0;
    localparam int D2 = 1;
    localparam int D3 = 2;

    logic        PCLK    = 1'b0;
    logic        PRESETN = 1'b0;
    logic [2:0]  psel    = '0;
    logic        penable = 1'b0;
    logic        pwrite  = 1'b0;
    logic [31:0] paddr   = '0;
    logic [31:0] pwdata  = '0;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc++;

    apb_slave_mem #(.AWIDTH(8), .WAIT_STATES(0), .TPD(1)) u_ws0 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[D0]),
        .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
        .PWDATA(pwdata), .PRDATA(prdata[D0]), .PREADY(pready[D0]),
        .PSLVERR(pslverr[D0])
    );

    apb_slave_mem #(.AWIDTH(8), .WAIT_STATES(2), .TPD(1)) u_ws2 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[D2]),
        .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
        .PWDATA(pwdata), .PRDATA(prdata[D2]), .PREADY(pready[D2]),
        .PSLVERR(pslverr[D2])
    );

    apb_slave_mem #(.AWIDTH(8), .WAIT_STATES(3), .TPD(1)) u_ws3 (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(psel[D3]),
        .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr),
        .PWDATA(pwdata), .PRDATA(prdata[D3]), .PREADY(pready[D3]),
        .PSLVERR(pslverr[D3])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One APB transfer; PWDATA carries junk until PREADY is seen.
    // With b2b set, PSEL stays high so the next call is a direct setup.
    task automatic xfer(input int d, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit b2b, output logic [31:0] rd,
                        output logic er, output int nw);
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = ~wd;
        @(posedge PCLK); #1;
        penable = 1'b1;
        nw = 0;
        while (pready[d] !== 1'b1 && nw < 40) begin
            @(posedge PCLK); #1;
            nw++;
        end
        rd = prdata[d];
        er = pslverr[d];
        pwdata = wd;
        @(posedge PCLK); #1;
        penable = 1'b0;
        if (!b2b) psel = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nw;
        int          c0;

        // reset state
        repeat (2) @(posedge PCLK);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_prdata", prdata[D0], 32'd0);
        PRESETN = 1'b1;

        // zero wait states: write then read back
        xfer(D0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, nw);
        chk("ws0_wr_waits", nw, 0);
        chk("ws0_wr_err", 32'(er), 32'd0);
        xfer(D0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, nw);
        chk("ws0_rd_waits", nw, 0);
        chk("ws0_rd_data", rd, 32'hDEADBEEF);
        chk("ws0_rd_err", 32'(er), 32'd0);
        chk("ws0_idle_pready", 32'(pready[D0]), 32'd0);
        chk("ws0_idle_prdata", prdata[D0], 32'd0);

        // three wait states
        xfer(D3, 1'b1, 32'h04, 32'h12345678, 1'b0, rd, er, nw);
        chk("ws3_wr_waits", nw, 3);
        xfer(D3, 1'b0, 32'h04, 32'h0, 1'b0, rd, er, nw);
        chk("ws3_rd_waits", nw, 3);
        chk("ws3_rd_data", rd, 32'h12345678);

        // address errors alias word 0 if not blocked
        xfer(D0, 1'b1, 32'h000, 32'hA5A5A5A5, 1'b0, rd, er, nw);
        xfer(D0, 1'b1, 32'h400, 32'h11111111, 1'b0, rd, er, nw);
        chk("err400_err", 32'(er), 32'd1);
        chk("err400_waits", nw, 0);
        xfer(D0, 1'b1, 32'h002, 32'h22222222, 1'b0, rd, er, nw);
        chk("err002_err", 32'(er), 32'd1);
        xfer(D0, 1'b0, 32'h000, 32'h0, 1'b0, rd, er, nw);
        chk("err_word0_data", rd, 32'hA5A5A5A5);
        chk("err_word0_err", 32'(er), 32'd0);
        xfer(D0, 1'b0, 32'h400, 32'h0, 1'b0, rd, er, nw);
        chk("err_rd_data", rd, 32'd0);
        chk("err_rd_err", 32'(er), 32'd1);

        // asynchronous reset while a read sits in READY
        psel = 3'b001;
        penable = 1'b0;
        pwrite = 1'b0;
        paddr = 32'h10;
        @(posedge PCLK); #1;
        chk("arst_pre_pready", 32'(pready[D0]), 32'd1);
        chk("arst_pre_prdata", prdata[D0], 32'hDEADBEEF);
        PRESETN = 1'b0;
        #2;
        chk("arst_pready", 32'(pready[D0]), 32'd0);
        chk("arst_prdata", prdata[D0], 32'd0);
        psel = '0;
        #1;
        PRESETN = 1'b1;

        // reset in the second WAIT cycle of a write drops it
        xfer(D2, 1'b1, 32'h08, 32'hCAFE0001, 1'b0, rd, er, nw);
        chk("ws2_wr_waits", nw, 2);
        psel = 3'b010;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h08;
        pwdata = 32'hBAD00BAD;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        chk("ws2_wait2_pready", 32'(pready[D2]), 32'd0);
        PRESETN = 1'b0;
        #2;
        chk("ws2_rst_pready", 32'(pready[D2]), 32'd0);
        chk("ws2_rst_pslverr", 32'(pslverr[D2]), 32'd0);
        psel = '0;
        penable = 1'b0;
        #1;
        PRESETN = 1'b1;
        xfer(D2, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, nw);
        chk("ws2_rd_waits", nw, 2);
        chk("ws2_rd_data", rd, 32'hCAFE0001);

        // PSEL dropped during WAIT aborts the write
        xfer(D3, 1'b1, 32'h0C, 32'h0C0C0C0C, 1'b0, rd, er, nw);
        psel = 3'b100;
        penable = 1'b0;
        pwrite = 1'b1;
        paddr = 32'h0C;
        pwdata = 32'hFFFF0000;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        psel = '0;
        penable = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_pready", 32'(pready[D3]), 32'd0);

        // access phase without setup is ignored
        psel = 3'b100;
        penable = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        chk("nosetup_pready", 32'(pready[D3]), 32'd0);
        psel = '0;
        penable = 1'b0;
        @(posedge PCLK); #1;
        xfer(D3, 1'b0, 32'h0C, 32'h0, 1'b0, rd, er, nw);
        chk("abort_rd_data", rd, 32'h0C0C0C0C);
        chk("abort_rd_waits", nw, 3);

        // ten back-to-back writes then ten back-to-back reads
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            xfer(D0, 1'b1, 32'(4 * i), 32'hA0000000 + 32'(i) * 32'h00010001,
                 1'b1, rd, er, nw);
        end
        for (int i = 0; i < 10; i++) begin
            xfer(D0, 1'b0, 32'(4 * i), 32'h0, (i != 9), rd, er, nw);
            chk($sformatf("b2b_rd_%0d", i), rd,
                32'hA0000000 + 32'(i) * 32'h00010001);
        end
        chk("b2b_cycles", cyc - c0, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
